// File: rtl/max10_devkit_top.sv
// MAX10 dev-kit top level: power-on BIST sequencer with scratch-register check,
// UART banner transmit ("OK\r\n"), hierarchical test-result registers,
// progress LEDs and a parked QSPI flash interface.
// Optional build macro: BIST_UART_LOOPBACK_EN adds an internal loopback receiver
// that checks every transmitted byte.

// Test-result registers, read hierarchically by benches and debuggers.
module max10_testregs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prog_we,
    input  logic [31:0] prog_val,
    input  logic        pass_we,
    input  logic [31:0] pass_val,
    input  logic        fail_we,
    input  logic [31:0] fail_val,
    output logic [31:0] progress,
    output logic [31:0] pass_word,
    output logic [31:0] fail_word
);
    logic [31:0] TEST_PROGRESS;
    logic [31:0] TEST_PASS;
    logic [31:0] TEST_FAIL;

    // Result registers; the sequencer guarantees pass and fail are never both written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TEST_PROGRESS <= 32'h0;
            TEST_PASS     <= 32'h0;
            TEST_FAIL     <= 32'h0;
        end else begin
            if (prog_we) TEST_PROGRESS <= prog_val;
            if (pass_we) TEST_PASS     <= pass_val;
            if (fail_we) TEST_FAIL     <= fail_val;
        end
    end

    assign progress  = TEST_PROGRESS;
    assign pass_word = TEST_PASS;
    assign fail_word = TEST_FAIL;
endmodule

module max10_devkit_top #(
    parameter int          BAUD_DIV  = 434,
    parameter logic [31:0] PASS_CODE = 32'h600D_600D,
    parameter logic [31:0] FAIL_BASE = 32'hBAD0_0000
) (
    input  logic       clk_50,
    input  logic       fpga_reset_n,
    output logic       qspi_clk,
    inout  wire  [3:0] qspi_io,
    output logic       qspi_csn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [4:0] user_led,
    input  logic [3:0] user_pb
);
    localparam int             CW         = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0]  BAUD_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [31:0]    SCRATCH_PAT = 32'hA5A5_5A5A;

    typedef enum logic [2:0] {
        IDLE, SCRATCH_WR, SCRATCH_RD, UART_SEND, UART_WAIT, DONE, FAIL
    } bist_state_t;

    function automatic logic [7:0] banner_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    banner_byte = 8'h4F;
            2'd1:    banner_byte = 8'h4B;
            2'd2:    banner_byte = 8'h0D;
            default: banner_byte = 8'h0A;
        endcase
    endfunction

    // Flash stays deselected and released, even while in reset.
    assign qspi_clk = 1'b0;
    assign qspi_csn = 1'b1;
    assign qspi_io  = 4'bzzzz;

    logic [1:0] rst_sync;
    logic       rst_n;

    // Reset asserts asynchronously; release is retimed through two flops.
    always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) rst_sync <= 2'b00;
        else               rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [3:0] pb_meta, pb_sync, pb_prev;
    logic       pb_hit;

    // Pushbutton synchroniser plus one history stage for the two-sample hold check.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pb_meta <= 4'hF;
            pb_sync <= 4'hF;
            pb_prev <= 4'hF;
        end else begin
            pb_meta <= user_pb;
            pb_sync <= pb_meta;
            pb_prev <= pb_sync;
        end
    end
    assign pb_hit = |(~pb_sync & ~pb_prev);

    bist_state_t state, state_nx;
    logic [1:0]  byte_idx;
    logic [31:0] scratch;
    logic        tx_start, tx_busy, tx_line, byte_inc, scratch_we, byte_ok;
    logic [7:0]  tx_byte;
    logic [8:0]  tx_shift;
    logic [3:0]  tx_bit;
    logic [CW-1:0] tx_cnt;
    logic        prog_we, pass_we, fail_we;
    logic [31:0] prog_val;
    logic [15:0] fail_step;
    logic [31:0] progress, pass_word, fail_word;
    logic        heartbeat;
    logic [23:0] hb_cnt;

    assign tx_byte = banner_byte(byte_idx);

    // BIST state register.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // BIST next-state and register-write decode; a held button overrides any step.
    always_comb begin
        state_nx   = state;
        tx_start   = 1'b0;
        scratch_we = 1'b0;
        byte_inc   = 1'b0;
        prog_we    = 1'b0;
        prog_val   = 32'h0;
        pass_we    = 1'b0;
        fail_we    = 1'b0;
        fail_step  = 16'h0;
        case (state)
            IDLE: begin
                prog_we  = 1'b1;
                prog_val = 32'd1;
                state_nx = SCRATCH_WR;
            end
            SCRATCH_WR: begin
                scratch_we = 1'b1;
                prog_we    = 1'b1;
                prog_val   = 32'd2;
                state_nx   = SCRATCH_RD;
            end
            SCRATCH_RD: begin
                if (scratch != SCRATCH_PAT) begin
                    fail_we   = 1'b1;
                    fail_step = 16'd2;
                    state_nx  = FAIL;
                end else begin
                    prog_we  = 1'b1;
                    prog_val = 32'd3;
                    state_nx = UART_SEND;
                end
            end
            UART_SEND: begin
                prog_we  = 1'b1;
                prog_val = 32'd4;
                tx_start = 1'b1;
                state_nx = UART_WAIT;
            end
            UART_WAIT: begin
                if (!tx_busy) begin
                    if (!byte_ok) begin
                        fail_we   = 1'b1;
                        fail_step = 16'd4;
                        state_nx  = FAIL;
                    end else if (byte_idx == 2'd3) begin
                        state_nx = DONE;
                    end else begin
                        byte_inc = 1'b1;
                        state_nx = UART_SEND;
                    end
                end
            end
            DONE: begin
                prog_we  = 1'b1;
                prog_val = 32'd5;
                pass_we  = 1'b1;
            end
            default: ;
        endcase
        if (state != DONE && state != FAIL && pb_hit) begin
            state_nx   = FAIL;
            tx_start   = 1'b0;
            scratch_we = 1'b0;
            byte_inc   = 1'b0;
            prog_we    = 1'b0;
            pass_we    = 1'b0;
            fail_we    = 1'b1;
            fail_step  = 16'd15;
        end
    end

    // Scratch register and banner byte index.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            scratch  <= 32'h0;
            byte_idx <= 2'd0;
        end else begin
            if (scratch_we) scratch  <= SCRATCH_PAT;
            if (byte_inc)   byte_idx <= byte_idx + 2'd1;
        end
    end

    // 8N1 transmitter; stays busy one extra idle bit so frames never abut.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_shift <= 9'h1FF;
            tx_bit   <= 4'd0;
            tx_cnt   <= '0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_shift <= {1'b1, tx_byte};
            tx_bit   <= 4'd0;
            tx_cnt   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == BAUD_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd10) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end
    assign uart_tx = tx_line;

`ifdef BIST_UART_LOOPBACK_EN
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    logic          rx_busy, rx_valid, rx_match;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;

    // Loopback receiver on the internal transmit line, sampling mid-bit.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy  <= 1'b0;
            rx_valid <= 1'b0;
            rx_match <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= 4'd0;
            rx_shift <= 8'h0;
        end else begin
            if (tx_start) rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (!tx_line) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF;
                    rx_bit  <= 4'd0;
                end
            end else begin
                rx_cnt <= (rx_cnt == BAUD_LAST) ? '0 : rx_cnt + 1'b1;
                if (rx_cnt == HALF) begin
                    if (rx_bit == 4'd0) begin
                        if (tx_line) rx_busy <= 1'b0;
                        else         rx_bit  <= 4'd1;
                    end else if (rx_bit <= 4'd8) begin
                        rx_shift <= {tx_line, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 4'd1;
                    end else begin
                        rx_busy  <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_match <= tx_line && (rx_shift == tx_byte);
                    end
                end
            end
        end
    end
    assign byte_ok = rx_valid && rx_match;
`else
    assign byte_ok = 1'b1;
`endif

    max10_testregs raccoon_testregs (
        .clk       (clk_50),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_val  (prog_val),
        .pass_we   (pass_we),
        .pass_val  (PASS_CODE),
        .fail_we   (fail_we),
        .fail_val  (FAIL_BASE | {16'h0, fail_step}),
        .progress  (progress),
        .pass_word (pass_word),
        .fail_word (fail_word)
    );

    // Heartbeat flips once per 2^24 clocks.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt    <= 24'h0;
            heartbeat <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 24'd1;
            if (hb_cnt == 24'hFF_FFFF) heartbeat <= ~heartbeat;
        end
    end

    assign user_led = {~heartbeat, ~progress[3:0]};

    // Result words are for hierarchical readers; uart_rx is deliberately unused.
    wire unused_sinks = &{1'b0, pass_word, fail_word, progress[31:4], uart_rx};
endmodule

// File: tb/tb_max10_devkit_top.sv
// Bench for max10_devkit_top at BAUD_DIV=4: nominal pass, UART framing,
// pushbutton abort, randomized button presses, mid-transmit reset.
module tb_max10_devkit_top;
    localparam int          BD        = 4;
    localparam logic [31:0] PASS_CODE = 32'h600D_600D;
    localparam logic [31:0] FAIL_PB   = 32'hBAD0_000F;
    localparam logic [31:0] FAIL_LB   = 32'hBAD0_0004;

    logic       clk_50 = 1'b0;
    logic       clk_run = 1'b0;
    logic       fpga_reset_n;
    logic       qspi_clk, qspi_csn, uart_tx;
    logic       uart_rx;
    logic [4:0] user_led;
    logic [3:0] user_pb;
    wire  [3:0] qspi_io;

    pullup (qspi_io[0]);
    pullup (qspi_io[1]);
    pullup (qspi_io[2]);
    pullup (qspi_io[3]);

    max10_devkit_top #(.BAUD_DIV(BD)) dut (
        .clk_50       (clk_50),
        .fpga_reset_n (fpga_reset_n),
        .qspi_clk     (qspi_clk),
        .qspi_io      (qspi_io),
        .qspi_csn     (qspi_csn),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx),
        .user_led     (user_led),
        .user_pb      (user_pb)
    );

    always begin
        #5;
        if (clk_run) clk_50 = ~clk_50;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: banner text, progress sequence, expected line waveform.
    logic [7:0] banner [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    int         exp_prog [5] = '{1, 2, 3, 4, 5};

    function automatic logic [39:0] frame_wave(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] w;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) w[i] = bits[i / BD];
        return w;
    endfunction

    // Line monitor: captures 40 samples per frame and the idle gap before it.
    logic [39:0] wave_q[$];
    int          gap_q[$];
    int          idle_run = 0;
    bit          seen = 0;
    bit          mon_en = 0;

    initial begin : monitor
        logic [39:0] s;
        forever begin
            @(negedge clk_50);
            if (!mon_en) begin
                idle_run = 0;
                seen = 0;
            end else if (uart_tx === 1'b1) begin
                idle_run++;
            end else begin
                s[0] = uart_tx;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk_50);
                    s[i] = uart_tx;
                end
                wave_q.push_back(s);
                if (seen) gap_q.push_back(idle_run);
                seen = 1;
                idle_run = 0;
            end
        end
    end

    int prog_q[$];

    task automatic run_to_end(output int cycles, output bit reached);
        int last;
        last = int'(dut.raccoon_testregs.TEST_PROGRESS);
        reached = 0;
        cycles = 0;
        prog_q.delete();
        for (int c = 0; c < 400 && !reached; c++) begin
            @(negedge clk_50);
            cycles = c + 1;
            if (int'(dut.raccoon_testregs.TEST_PROGRESS) != last) begin
                last = int'(dut.raccoon_testregs.TEST_PROGRESS);
                prog_q.push_back(last);
            end
            if (dut.raccoon_testregs.TEST_PASS != 0 || dut.raccoon_testregs.TEST_FAIL != 0)
                reached = 1;
        end
    endtask

    task automatic do_reset(input logic [3:0] pb);
        @(negedge clk_50);
        fpga_reset_n = 1'b0;
        mon_en = 0;
        user_pb = pb;
        repeat (50) @(negedge clk_50);
        wave_q.delete();
        gap_q.delete();
        fpga_reset_n = 1'b1;
        mon_en = 1;
    endtask

    task automatic check_full_pass(input string tag);
        int cyc;
        bit ok;
        run_to_end(cyc, ok);
        check({tag, "_reached"}, 64'(ok), 64'd1);
        check({tag, "_within_300"}, 64'(cyc <= 300), 64'd1);
        check({tag, "_pass"}, 64'(dut.raccoon_testregs.TEST_PASS), 64'(PASS_CODE));
        check({tag, "_fail"}, 64'(dut.raccoon_testregs.TEST_FAIL), 64'd0);
        check({tag, "_nsteps"}, 64'(prog_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < prog_q.size(); i++)
            check($sformatf("%s_step%0d", tag, i), 64'(prog_q[i]), 64'(exp_prog[i]));
        check({tag, "_led"}, 64'(user_led[3:0]), 64'(4'b1010));
        check({tag, "_nframes"}, 64'(wave_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < wave_q.size(); i++)
            check($sformatf("%s_frame%0d", tag, i), 64'(wave_q[i]), 64'(frame_wave(banner[i])));
        for (int i = 0; i < gap_q.size(); i++)
            check($sformatf("%s_gap%0d_ge_bit", tag, i), 64'(gap_q[i] >= BD), 64'd1);
    endtask

    initial begin : stim
        int cyc;
        bit ok;
        int d, st;
        logic [3:0] mask;

        // Power up briefly, then stop the clock and assert reset asynchronously.
        fpga_reset_n = 1'b1;
        user_pb = 4'hF;
        uart_rx = 1'b1;
        clk_run = 1'b1;
        repeat (5) @(posedge clk_50);
        @(negedge clk_50);
        clk_run = 1'b0;
        #20;
        fpga_reset_n = 1'b0;
        #20;
        check("rst_progress", 64'(dut.raccoon_testregs.TEST_PROGRESS), 64'd0);
        check("rst_pass", 64'(dut.raccoon_testregs.TEST_PASS), 64'd0);
        check("rst_fail", 64'(dut.raccoon_testregs.TEST_FAIL), 64'd0);
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_led", 64'(user_led), 64'h1F);
        check("rst_qspi_clk", 64'(qspi_clk), 64'd0);
        check("rst_qspi_csn", 64'(qspi_csn), 64'd1);
        check("rst_qspi_io_released", 64'(qspi_io), 64'hF);

        // Release, then start the clock: nominal pass.
        fpga_reset_n = 1'b1;
        #20;
        mon_en = 1;
        clk_run = 1'b1;
        check_full_pass("nominal");
        check("done_qspi_clk", 64'(qspi_clk), 64'd0);
        check("done_qspi_csn", 64'(qspi_csn), 64'd1);
        check("done_qspi_io_released", 64'(qspi_io), 64'hF);

        // Buttons are ignored once DONE.
        user_pb = 4'b0110;
        repeat (8) @(negedge clk_50);
        user_pb = 4'hF;
        repeat (4) @(negedge clk_50);
        check("done_pb_fail", 64'(dut.raccoon_testregs.TEST_FAIL), 64'd0);
        check("done_pb_pass", 64'(dut.raccoon_testregs.TEST_PASS), 64'(PASS_CODE));

        // Button held from release aborts with step 15.
        do_reset(4'b1110);
        run_to_end(cyc, ok);
        check("pbhold_reached", 64'(ok), 64'd1);
        check("pbhold_fail", 64'(dut.raccoon_testregs.TEST_FAIL), 64'(FAIL_PB));
        check("pbhold_pass", 64'(dut.raccoon_testregs.TEST_PASS), 64'd0);
        user_pb = 4'hF;

        // Randomized presses: a press abort needs at least two consecutive samples.
        for (int k = 0; k < 4; k++) begin
            mask = 4'($urandom_range(1, 15));
            d    = (k == 0) ? 1 : (k == 1) ? 2 : int'($urandom_range(1, 4));
            st   = int'($urandom_range(5, 60));
            do_reset(4'hF);
            repeat (st) @(posedge clk_50);
            #1 user_pb = ~mask;
            repeat (d) @(posedge clk_50);
            #1 user_pb = 4'hF;
            run_to_end(cyc, ok);
            check($sformatf("rndpb%0d_reached", k), 64'(ok), 64'd1);
            check($sformatf("rndpb%0d_d%0d_fail", k, d), 64'(dut.raccoon_testregs.TEST_FAIL),
                  64'((d >= 2) ? FAIL_PB : 32'h0));
            check($sformatf("rndpb%0d_d%0d_pass", k, d), 64'(dut.raccoon_testregs.TEST_PASS),
                  64'((d >= 2) ? 32'h0 : PASS_CODE));
        end

        // Reset in the middle of a low UART bit takes effect without a clock edge.
        do_reset(4'hF);
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_50);
            ok = (dut.raccoon_testregs.TEST_PROGRESS == 32'd4);
        end
        check("mid_reach_uart", 64'(ok), 64'd1);
        repeat ($urandom_range(5, 100)) @(negedge clk_50);
        ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk_50);
            ok = (uart_tx == 1'b0);
        end
        check("mid_found_low_bit", 64'(ok), 64'd1);
        #1 fpga_reset_n = 1'b0;
        #1;
        check("mid_progress", 64'(dut.raccoon_testregs.TEST_PROGRESS), 64'd0);
        check("mid_uart_tx", 64'(uart_tx), 64'd1);
        check("mid_led", 64'(user_led), 64'h1F);
        check("mid_qspi_csn", 64'(qspi_csn), 64'd1);
        do_reset(4'hF);
        check_full_pass("rerun");

`ifdef BIST_UART_LOOPBACK_EN
        // Invert one data bit (bit 4 of 0x4F, nominally 0) on the internal line.
        do_reset(4'hF);
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_50);
            ok = (dut.raccoon_testregs.TEST_PROGRESS == 32'd4) && (uart_tx == 1'b0);
        end
        check("lb_found_start", 64'(ok), 64'd1);
        repeat (5 * BD) @(posedge clk_50);
        #1 force dut.tx_line = 1'b1;
        repeat (BD - 1) @(posedge clk_50);
        #1 release dut.tx_line;
        run_to_end(cyc, ok);
        check("lb_reached", 64'(ok), 64'd1);
        check("lb_fail", 64'(dut.raccoon_testregs.TEST_FAIL), 64'(FAIL_LB));
        check("lb_pass", 64'(dut.raccoon_testregs.TEST_PASS), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
